// File: rtl/placement_readback.sv
// Reads back the placer's result from the pos_X/pos_Y and grid RAMs, cross-checks each node
// against the grid, and streams one (node,x,y,flags) record per node with running totals.
//
// state     | meaning
// ----------|---------------------------------------------------------------
// S_IDLE    | waiting for start; counters hold last scan's totals
// S_RDPOS   | pos_X/pos_Y read strobe out, addrP = current node
// S_WPOS    | RAM latency wait
// S_CAPPOS  | capture x,y; classify unplaced / out-of-range / needs grid check
// S_RDGRID  | grid read strobe out at x*N+y
// S_WGRID   | RAM latency wait
// S_CAPGRID | compare grid word against node id
// S_EMIT    | record valid, waiting for rec_ready
// S_DONE    | one-cycle done pulse, then back to idle
module placement_readback #(
  parameter int N       = 6,
  parameter int N_NODES = 36,
  parameter int DW      = 32,
  parameter int POS_AW  = 7,
  parameter int GRID_AW = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               rePX,
  output logic               rePY,
  output logic [POS_AW-1:0]  addrP,
  input  logic [DW-1:0]      doutPX,
  input  logic [DW-1:0]      doutPY,
  output logic               reGrid,
  output logic [GRID_AW-1:0] addrGrid,
  input  logic [DW-1:0]      doutGrid,
  output logic               rec_valid,
  input  logic               rec_ready,
  output logic [DW-1:0]      rec_node,
  output logic [DW-1:0]      rec_x,
  output logic [DW-1:0]      rec_y,
  output logic [2:0]         rec_flags,
  output logic [DW-1:0]      placed_cnt,
  output logic [DW-1:0]      err_cnt
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RDPOS,
    S_WPOS,
    S_CAPPOS,
    S_RDGRID,
    S_WGRID,
    S_CAPGRID,
    S_EMIT,
    S_DONE
  } state_t;

  localparam logic signed [DW-1:0] NEG_ONE   = '1;
  localparam logic signed [DW-1:0] ZERO      = '0;
  localparam logic signed [DW-1:0] MAX_COORD = DW'(N - 1);
  localparam logic signed [DW-1:0] N_S       = DW'(N);
  localparam logic [POS_AW-1:0]    LAST_IDX  = POS_AW'(N_NODES - 1);

  state_t state, state_nxt;
  logic [POS_AW-1:0] idx, idx_nxt;

  logic signed [DW-1:0] pos_x, pos_y;
  logic                 unplaced, out_of_range, grid_mis, last, accept;
  logic [DW-1:0]        idx_ext;

  assign pos_x        = $signed(doutPX);
  assign pos_y        = $signed(doutPY);
  // The -1 sentinel takes priority over the range test, so a -1 never reads as range_err.
  assign unplaced     = (pos_x == NEG_ONE) || (pos_y == NEG_ONE);
  assign out_of_range = (pos_x < ZERO) || (pos_x > MAX_COORD) ||
                        (pos_y < ZERO) || (pos_y > MAX_COORD);
  assign idx_ext      = {{(DW-POS_AW){1'b0}}, idx};
  assign grid_mis     = (doutGrid != idx_ext);
  assign last         = (idx == LAST_IDX);
  assign accept       = (state == S_EMIT) && rec_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_RDPOS;
          idx_nxt   = '0;
        end
      end
      S_RDPOS:   state_nxt = S_WPOS;
      S_WPOS:    state_nxt = S_CAPPOS;
      S_CAPPOS:  state_nxt = (unplaced || out_of_range) ? S_EMIT : S_RDGRID;
      S_RDGRID:  state_nxt = S_WGRID;
      S_WGRID:   state_nxt = S_CAPGRID;
      S_CAPGRID: state_nxt = S_EMIT;
      S_EMIT: begin
        if (rec_ready) begin
          if (last) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_RDPOS;
            idx_nxt   = idx + POS_AW'(1);
          end
        end
      end
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Strobes and status are registered off the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      rePX       <= 1'b0;
      rePY       <= 1'b0;
      addrP      <= '0;
      reGrid     <= 1'b0;
      addrGrid   <= '0;
      rec_valid  <= 1'b0;
      rec_node   <= '0;
      rec_x      <= '0;
      rec_y      <= '0;
      rec_flags  <= '0;
      placed_cnt <= '0;
      err_cnt    <= '0;
    end else begin
      busy      <= (state_nxt != S_IDLE);
      done      <= (state_nxt == S_DONE);
      rePX      <= (state_nxt == S_RDPOS);
      rePY      <= (state_nxt == S_RDPOS);
      reGrid    <= (state_nxt == S_RDGRID);
      rec_valid <= (state_nxt == S_EMIT);

      if (state_nxt == S_RDPOS) begin
        addrP <= idx_nxt;
      end

      if ((state == S_IDLE) && start) begin
        placed_cnt <= '0;
        err_cnt    <= '0;
      end

      if (state == S_CAPPOS) begin
        rec_node  <= idx_ext;
        rec_x     <= doutPX;
        rec_y     <= doutPY;
        rec_flags <= {out_of_range && !unplaced, 1'b0, unplaced};
        if (!unplaced && !out_of_range) begin
          // Full-width product first, then truncation to the grid address width.
          addrGrid <= GRID_AW'(pos_x * N_S + pos_y);
        end
      end

      if (state == S_CAPGRID) begin
        rec_flags[1] <= grid_mis;
      end

      if (accept) begin
        if (rec_flags == 3'b000) begin
          placed_cnt <= placed_cnt + DW'(1);
        end else begin
          err_cnt <= err_cnt + DW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_placement_readback.sv
// Directed scenarios for placement_readback with a RAM model and a record scoreboard.
module tb_placement_readback;
  localparam int N  = 6;
  localparam int NN = 36;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        rec_ready = 1'b0;
  logic        busy, done, rePX, rePY, reGrid, rec_valid;
  logic [6:0]  addrP;
  logic [11:0] addrGrid;
  logic [31:0] doutPX, doutPY, doutGrid;
  logic [31:0] rec_node, rec_x, rec_y, placed_cnt, err_cnt;
  logic [2:0]  rec_flags;

  always #5 clk = ~clk;

  placement_readback #(.N(6), .N_NODES(36), .DW(32), .POS_AW(7), .GRID_AW(12)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .rePX(rePX), .rePY(rePY), .addrP(addrP), .doutPX(doutPX), .doutPY(doutPY),
    .reGrid(reGrid), .addrGrid(addrGrid), .doutGrid(doutGrid),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_node(rec_node),
    .rec_x(rec_x), .rec_y(rec_y), .rec_flags(rec_flags),
    .placed_cnt(placed_cnt), .err_cnt(err_cnt)
  );

  int pos_x [0:127];
  int pos_y [0:127];
  int grid  [0:4095];

  // Two-cycle read pipeline; outside a read window the data bus carries junk.
  logic        v_p1, v_g1;
  logic [31:0] px1, py1, g1;
  always @(posedge clk) begin
    v_p1     <= rePX;
    px1      <= pos_x[addrP];
    py1      <= pos_y[addrP];
    doutPX   <= v_p1 ? px1 : 32'hDEAD_BEEF;
    doutPY   <= v_p1 ? py1 : 32'hDEAD_BEEF;
    v_g1     <= reGrid;
    g1       <= grid[addrGrid];
    doutGrid <= v_g1 ? g1 : 32'hDEAD_BEEF;
  end

  typedef struct {
    logic [31:0] node;
    logic [31:0] x;
    logic [31:0] y;
    logic [2:0]  flags;
  } rec_t;

  rec_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  int   grid_rd_cnt = 0;
  int   rec_cnt = 0;
  bit   hold_prev = 1'b0;
  rec_t held;
  int   ga;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] model_flags(input int k);
    int x, y;
    x = pos_x[k];
    y = pos_y[k];
    if (x == -1 || y == -1) return 3'b001;
    if (x < 0 || x > N - 1 || y < 0 || y > N - 1) return 3'b100;
    if (grid[x * N + y] != k) return 3'b010;
    return 3'b000;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      if (done) done_cnt++;
      if (rePX || rePY) check("re_pair", 32'(rePY), 32'(rePX));
      if (reGrid) begin
        grid_rd_cnt++;
        ga = pos_x[addrP] * N + pos_y[addrP];
        check("grid_addr", 32'(addrGrid), 32'(ga[11:0]));
      end
      if (hold_prev) begin
        check("hold_valid", 32'(rec_valid), 32'd1);
        check("hold_node", rec_node, held.node);
        check("hold_x", rec_x, held.x);
        check("hold_y", rec_y, held.y);
        check("hold_flags", 32'(rec_flags), 32'(held.flags));
      end
      if (rec_valid && rec_ready) begin
        rec_cnt++;
        total++;
        assert (sb.size() > 0) else begin
          bad++;
          $error("FAIL sb_underflow observed=record %0d expected=none", rec_node);
        end
        if (sb.size() > 0) begin
          rec_t e;
          e = sb.pop_front();
          check("rec_node", rec_node, e.node);
          check("rec_x", rec_x, e.x);
          check("rec_y", rec_y, e.y);
          check("rec_flags", 32'(rec_flags), 32'(e.flags));
        end
      end
      hold_prev   = rec_valid && !rec_ready;
      held.node   = rec_node;
      held.x      = rec_x;
      held.y      = rec_y;
      held.flags  = rec_flags;
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic load_legal();
    for (int i = 0; i < 4096; i++) grid[i] = 1000;
    for (int k = 0; k < 128; k++) begin
      pos_x[k] = -1;
      pos_y[k] = -1;
    end
    for (int k = 0; k < NN; k++) begin
      pos_x[k] = k / N;
      pos_y[k] = k % N;
      grid[(k / N) * N + (k % N)] = k;
    end
  endtask

  task automatic push_expected(output int exp_grid);
    sb.delete();
    exp_grid = 0;
    for (int k = 0; k < NN; k++) begin
      rec_t r;
      r.node  = k;
      r.x     = pos_x[k];
      r.y     = pos_y[k];
      r.flags = model_flags(k);
      sb.push_back(r);
      if (!(r.flags == 3'b001 || r.flags == 3'b100)) exp_grid++;
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic outputs_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_rePX"}, 32'(rePX), 32'd0);
    check({tag, "_rePY"}, 32'(rePY), 32'd0);
    check({tag, "_addrP"}, 32'(addrP), 32'd0);
    check({tag, "_reGrid"}, 32'(reGrid), 32'd0);
    check({tag, "_addrGrid"}, 32'(addrGrid), 32'd0);
    check({tag, "_rec_valid"}, 32'(rec_valid), 32'd0);
    check({tag, "_rec_node"}, rec_node, 32'd0);
    check({tag, "_rec_x"}, rec_x, 32'd0);
    check({tag, "_rec_y"}, rec_y, 32'd0);
    check({tag, "_rec_flags"}, 32'(rec_flags), 32'd0);
    check({tag, "_placed"}, placed_cnt, 32'd0);
    check({tag, "_err"}, err_cnt, 32'd0);
  endtask

  task automatic run_scan(input string tag, input bit rnd, input bit poke,
                          input int exp_placed, input int exp_err);
    int  eg, base_done, base_grid, base_rec;
    bit  seen;
    push_expected(eg);
    base_done = done_cnt;
    base_grid = grid_rd_cnt;
    base_rec  = rec_cnt;
    pulse_start();
    check({tag, "_busy_on"}, 32'(busy), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(posedge clk); #1;
      if (rnd) rec_ready = ($urandom_range(0, 99) < 30);
      if (poke) start = (i == 40);
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    @(posedge clk); #1;
    rec_ready = 1'b1;
    check({tag, "_busy_off"}, 32'(busy), 32'd0);
    check({tag, "_done_1cyc"}, 32'(done), 32'd0);
    check({tag, "_valid_off"}, 32'(rec_valid), 32'd0);
    check({tag, "_placed"}, placed_cnt, 32'(exp_placed));
    check({tag, "_err"}, err_cnt, 32'(exp_err));
    check({tag, "_sum"}, placed_cnt + err_cnt, 32'(NN));
    check({tag, "_done_cnt"}, 32'(done_cnt - base_done), 32'd1);
    check({tag, "_rec_cnt"}, 32'(rec_cnt - base_rec), 32'(NN));
    check({tag, "_sb_left"}, 32'(sb.size()), 32'd0);
    check({tag, "_grid_reads"}, 32'(grid_rd_cnt - base_grid), 32'(eg));
  endtask

  initial begin
    int  eg, base_done;
    bit  seen;
    load_legal();
    repeat (2) @(posedge clk);
    #1 outputs_zero("rst");
    reset = 1'b1;
    rec_ready = 1'b1;

    load_legal();
    run_scan("s1_legal", 1'b0, 1'b0, 36, 0);

    load_legal();
    pos_x[5] = -1;
    run_scan("s2_unplaced", 1'b0, 1'b0, 35, 1);

    load_legal();
    pos_x[7] = 6;
    pos_y[8] = -2;
    run_scan("s3_range", 1'b0, 1'b0, 34, 2);

    load_legal();
    grid[14] = 9;
    run_scan("s4_mismatch", 1'b0, 1'b0, 35, 1);

    load_legal();
    run_scan("s5_backpressure", 1'b1, 1'b0, 36, 0);

    load_legal();
    push_expected(eg);
    base_done = done_cnt;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (reGrid && addrP == 7'd20) seen = 1'b1;
    end
    check("s6_reach_node20", 32'(seen), 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    #1 outputs_zero("s6_abort");
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("s6_idle_busy", 32'(busy), 32'd0);
    check("s6_no_done", 32'(done_cnt - base_done), 32'd0);
    check("s6_idle_valid", 32'(rec_valid), 32'd0);
    sb.delete();
    run_scan("s6_rescan", 1'b0, 1'b1, 36, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
